vmatmul_ctrl: RTL and testbench
===============================

Name: vmatmul_ctrl

Overview:
- Sequencer for the vector matrix-multiply datapath: C[i][j] += A[i][k] * B[k][j].
- Latches matrix base addresses and shape on a start handshake, then walks the loop nest (i outer, j middle, k inner) at one iteration per cycle.
- Per iteration it drives indices, element byte addresses and accumulate qualifiers to the datapath/vmem, honours a stall from the memory side, and reports completion or error.

Parameters:
- ADDR_W, 32, width of base and element byte addresses.
- DIM_W, 16, width of each dimension and index.
- CNT_W, 32, width of the issued-iteration counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a new multiply; sampled only in IDLE.
- addr_m1 / addr_m2 / addr_m3  in  ADDR_W  base byte addresses of A, B and C; latched on start accept.
- num_i / num_j / num_k  in  DIM_W  shape: A is num_i x num_k, B is num_k x num_j, C is num_i x num_j; latched on start accept.
- stall  in  1  datapath cannot accept the current iteration; hold everything.
- abort  in  1  terminate the current run.
- busy  out  1  high in CHECK and RUN.
- done  out  1  one-cycle completion pulse.
- err  out  1  run ended by zero dimension or abort; sticky until the next start accept.
- iter_valid  out  1  current index/address outputs are a real iteration.
- cur_i / cur_j / cur_k  out  DIM_W  current loop indices.
- addr_a / addr_b / addr_c  out  ADDR_W  addresses of A[i][k], B[k][j] and C[i][j].
- acc_clear  out  1  iter_valid and cur_k == 0 (first partial product: overwrite C).
- acc_last  out  1  iter_valid and cur_k == num_k-1.
- iter_count  out  CNT_W  iterations accepted in this run; wraps modulo 2^CNT_W.

Behaviour:
- On reset:
  - state = IDLE.
  - busy, done, err, iter_valid, acc_clear, acc_last = 0.
  - All indices, addresses, iter_count and latched configuration = 0.
- States:
  - IDLE: accept start, latch configuration, clear err and iter_count, go to CHECK.
  - CHECK: one cycle. If any dimension is 0, set err = 1 and go to DONE. Otherwise set indices to 0 and go to RUN.
  - RUN: issue iterations.
  - DONE: done = 1 for exactly one cycle, busy = 0, then IDLE.
- start is ignored outside IDLE, including in DONE.
- Latency: start accepted at edge t, CHECK in cycle t+1, first iter_valid (i = j = k = 0) in cycle t+2.
- In RUN, iter_valid = 1. An iteration is accepted on a cycle where iter_valid = 1 and stall = 0.
- Index advance after an accepted iteration:
  - k+1 if k < num_k-1.
  - Otherwise k = 0 and j+1 if j < num_j-1.
  - Otherwise j = 0, k = 0 and i+1.
- Accepting iteration (num_i-1, num_j-1, num_k-1) moves to DONE the next cycle, with iter_valid = 0 and err = 0.
- Total accepted iterations = num_i * num_j * num_k; iter_count increments once per accepted iteration.
- Stall: all outputs and state held; stall may last any number of cycles.
- Abort:
  - In RUN, abort overrides stall and a same-cycle last accept. Next cycle is DONE with err = 1 and iter_valid = 0; an aborted iteration is not counted.
  - Abort in IDLE, CHECK or DONE has no effect.
- Address arithmetic, registered together with the indices, truncated to ADDR_W:
  - addr_a = addr_m1 + ((i*num_k + k) << 2)
  - addr_b = addr_m2 + ((k*num_j + j) << 2)
  - addr_c = addr_m3 + ((i*num_j + j) << 2)
  - Products are formed at 2*DIM_W width before truncation.
- Address updates are incremental: add 4, or row-step corrections precomputed in CHECK. No multiplier sits in the RUN path.
- Reset asserted mid-run: immediate return to reset values; no done pulse.

Decomposition:
- Shared package vmat_pkg holds:
  - State enum (IDLE, CHECK, RUN, DONE).
  - Element byte size constant ELEM_BYTES = 4 and shift constant ELEM_SHIFT = 2.
- Natural sub-module: vmat_loop_cnt, a three-level nested index counter with wrap and advance outputs. The address unit and FSM stay in vmatmul_ctrl.

Test Plan:
- 2x2x2 run, bases 0x100 / 0x200 / 0x300, no stall -> 8 consecutive iter_valid cycles starting 2 cycles after start; acc_clear on k = 0; addr_b for (k=1, j=0) = 0x208; addr_c for i = 1, j = 1 = 0x30C; done 1 cycle after last; iter_count = 8; err = 0.
- 1x3x4 run with stall held 3 cycles at iteration 5 -> index and address outputs frozen for those cycles; total accepted = 12; done timing shifted by exactly 3 cycles.
- num_j = 0 -> CHECK then done pulse with err = 1; iter_valid never high; iter_count = 0.
- 3x3x3 run, abort at iteration 10 -> next cycle done = 1, err = 1, iter_count = 10; a following start clears err and runs normally.
- start pulsed during RUN and during DONE -> ignored; latched shape unchanged.
- reset asserted asynchronously mid-run (not clock-aligned) -> outputs zero immediately; no done pulse; after release, a fresh 1x1x1 run gives a single iteration at addresses equal to the bases.

Source files
------------

// File: rtl/vmat_pkg.sv
// Shared definitions for the vector matrix-multiply sequencer.
package vmat_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      RUN,
      DONE
   } state_t;

   localparam int unsigned ELEM_BYTES = 4;
   localparam int unsigned ELEM_SHIFT = 2;

endpackage

// File: rtl/vmatmul_ctrl_if.sv
// Command, stall/abort and per-iteration output bundle of the matmul sequencer.
interface vmatmul_ctrl_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DIM_W  = 16,
   parameter int unsigned CNT_W  = 32
);

   logic              start;
   logic [ADDR_W-1:0] addr_m1;
   logic [ADDR_W-1:0] addr_m2;
   logic [ADDR_W-1:0] addr_m3;
   logic [DIM_W-1:0]  num_i;
   logic [DIM_W-1:0]  num_j;
   logic [DIM_W-1:0]  num_k;
   logic              stall;
   logic              abort;
   logic              busy;
   logic              done;
   logic              err;
   logic              iter_valid;
   logic [DIM_W-1:0]  cur_i;
   logic [DIM_W-1:0]  cur_j;
   logic [DIM_W-1:0]  cur_k;
   logic [ADDR_W-1:0] addr_a;
   logic [ADDR_W-1:0] addr_b;
   logic [ADDR_W-1:0] addr_c;
   logic              acc_clear;
   logic              acc_last;
   logic [CNT_W-1:0]  iter_count;

   modport master (
      output start, addr_m1, addr_m2, addr_m3, num_i, num_j, num_k, stall, abort,
      input  busy, done, err, iter_valid, cur_i, cur_j, cur_k,
      input  addr_a, addr_b, addr_c, acc_clear, acc_last, iter_count
   );

   modport slave (
      input  start, addr_m1, addr_m2, addr_m3, num_i, num_j, num_k, stall, abort,
      output busy, done, err, iter_valid, cur_i, cur_j, cur_k,
      output addr_a, addr_b, addr_c, acc_clear, acc_last, iter_count
   );

endinterface

// File: rtl/vmat_loop_cnt.sv
// Three-level nested index counter (i outer, j middle, k inner).
module vmat_loop_cnt #(
   parameter int unsigned DIM_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             adv,
   input  logic [DIM_W-1:0] num_i,
   input  logic [DIM_W-1:0] num_j,
   input  logic [DIM_W-1:0] num_k,
   output logic [DIM_W-1:0] cur_i,
   output logic [DIM_W-1:0] cur_j,
   output logic [DIM_W-1:0] cur_k,
   output logic             k_wrap,
   output logic             last,
   output logic             step_k,
   output logic             step_j,
   output logic             step_i
);

   logic j_wrap;
   logic i_wrap;

   assign k_wrap = (cur_k == num_k - DIM_W'(1));
   assign j_wrap = (cur_j == num_j - DIM_W'(1));
   assign i_wrap = (cur_i == num_i - DIM_W'(1));
   assign last   = k_wrap && j_wrap && i_wrap;

   assign step_k = adv && !k_wrap;
   assign step_j = adv && k_wrap && !j_wrap;
   assign step_i = adv && k_wrap && j_wrap;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_i <= '0;
         cur_j <= '0;
         cur_k <= '0;
      end else if (clr) begin
         cur_i <= '0;
         cur_j <= '0;
         cur_k <= '0;
      end else if (step_k) begin
         cur_k <= cur_k + DIM_W'(1);
      end else if (step_j) begin
         cur_k <= '0;
         cur_j <= cur_j + DIM_W'(1);
      end else if (step_i) begin
         cur_k <= '0;
         cur_j <= '0;
         cur_i <= cur_i + DIM_W'(1);
      end
   end

endmodule

// File: rtl/vmatmul_ctrl.sv
// Matmul loop-nest sequencer: latches shape/bases, walks i/j/k one step per cycle
// and produces incrementally updated A/B/C element addresses.
module vmatmul_ctrl
   import vmat_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DIM_W  = 16,
   parameter int unsigned CNT_W  = 32
) (
   input logic          clk,
   input logic          reset,
   vmatmul_ctrl_if.slave bus
);

   localparam int unsigned PW = 2 * DIM_W;
   localparam logic [ADDR_W-1:0] ELEM = ADDR_W'(ELEM_BYTES);

   state_t            state;
   logic [ADDR_W-1:0] base_a, base_b, base_c;
   logic [DIM_W-1:0]  dim_i, dim_j, dim_k;
   logic [ADDR_W-1:0] step_b, rew_a, rew_b;
   logic [ADDR_W-1:0] addr_a, addr_b, addr_c;
   logic              busy, done, err, iter_valid;
   logic [CNT_W-1:0]  iter_count;

   logic [DIM_W-1:0]  cur_i, cur_j, cur_k;
   logic              k_wrap, last, step_k, step_j, step_i;
   logic              accept, adv, clr, dim_zero;
   logic [PW-1:0]     kj_prod;

   assign dim_zero = (dim_i == '0) || (dim_j == '0) || (dim_k == '0);
   assign accept   = iter_valid && !bus.stall && !bus.abort;
   assign adv      = accept && !last;
   assign clr      = (state == CHECK);
   // Only consumed while in CHECK, so the multiplier stays off the RUN path
   assign kj_prod  = PW'(dim_k - DIM_W'(1)) * PW'(dim_j);

   vmat_loop_cnt #(.DIM_W(DIM_W)) u_loop (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr),
      .adv    (adv),
      .num_i  (dim_i),
      .num_j  (dim_j),
      .num_k  (dim_k),
      .cur_i  (cur_i),
      .cur_j  (cur_j),
      .cur_k  (cur_k),
      .k_wrap (k_wrap),
      .last   (last),
      .step_k (step_k),
      .step_j (step_j),
      .step_i (step_i)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         base_a     <= '0;
         base_b     <= '0;
         base_c     <= '0;
         dim_i      <= '0;
         dim_j      <= '0;
         dim_k      <= '0;
         step_b     <= '0;
         rew_a      <= '0;
         rew_b      <= '0;
         addr_a     <= '0;
         addr_b     <= '0;
         addr_c     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         iter_valid <= 1'b0;
         iter_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  base_a     <= bus.addr_m1;
                  base_b     <= bus.addr_m2;
                  base_c     <= bus.addr_m3;
                  dim_i      <= bus.num_i;
                  dim_j      <= bus.num_j;
                  dim_k      <= bus.num_k;
                  err        <= 1'b0;
                  iter_count <= '0;
                  busy       <= 1'b1;
                  state      <= CHECK;
               end
            end
            CHECK: begin
               step_b <= ADDR_W'(dim_j) << ELEM_SHIFT;
               rew_a  <= ADDR_W'(dim_k - DIM_W'(1)) << ELEM_SHIFT;
               rew_b  <= ADDR_W'(kj_prod) << ELEM_SHIFT;
               addr_a <= base_a;
               addr_b <= base_b;
               addr_c <= base_c;
               if (dim_zero) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  iter_valid <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               if (bus.abort) begin
                  iter_valid <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  err        <= 1'b1;
                  state      <= DONE;
               end else if (!bus.stall) begin
                  iter_count <= iter_count + CNT_W'(1);
                  if (last) begin
                     iter_valid <= 1'b0;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     state      <= DONE;
                  end else if (step_k) begin
                     addr_a <= addr_a + ELEM;
                     addr_b <= addr_b + step_b;
                  end else if (step_j) begin
                     // A rewinds to row start, B rewinds to row 0 one column on
                     addr_a <= addr_a - rew_a;
                     addr_b <= addr_b - rew_b + ELEM;
                     addr_c <= addr_c + ELEM;
                  end else if (step_i) begin
                     addr_a <= addr_a + ELEM;
                     addr_b <= base_b;
                     addr_c <= addr_c + ELEM;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy       = busy;
   assign bus.done       = done;
   assign bus.err        = err;
   assign bus.iter_valid = iter_valid;
   assign bus.cur_i      = cur_i;
   assign bus.cur_j      = cur_j;
   assign bus.cur_k      = cur_k;
   assign bus.addr_a     = addr_a;
   assign bus.addr_b     = addr_b;
   assign bus.addr_c     = addr_c;
   assign bus.acc_clear  = iter_valid && (cur_k == '0);
   assign bus.acc_last   = iter_valid && k_wrap;
   assign bus.iter_count = iter_count;

endmodule

// File: tb/tb_vmatmul_ctrl.sv
// Directed bench for vmatmul_ctrl with an expected-iteration scoreboard.
module tb_vmatmul_ctrl;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DIM_W  = 16;
   localparam int unsigned CNT_W  = 32;

   typedef struct packed {
      logic [15:0] i;
      logic [15:0] j;
      logic [15:0] k;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic        clr;
      logic        last;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   total_acc = 0;
   int   total_valid = 0;
   int   run_base_acc = 0;
   int   run_base_valid = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vmatmul_ctrl_if #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .CNT_W(CNT_W)) bus ();

   vmatmul_ctrl #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_run(input int ni, input int nj, input int nk,
                           input logic [31:0] m1, input logic [31:0] m2, input logic [31:0] m3);
      exp_t e;
      for (int i = 0; i < ni; i++)
         for (int j = 0; j < nj; j++)
            for (int k = 0; k < nk; k++) begin
               e.i    = 16'(i);
               e.j    = 16'(j);
               e.k    = 16'(k);
               e.a    = m1 + 32'((i * nk + k) * 4);
               e.b    = m2 + 32'((k * nj + j) * 4);
               e.c    = m3 + 32'((i * nj + j) * 4);
               e.clr  = (k == 0);
               e.last = (k == nk - 1);
               sb.push_back(e);
            end
   endtask

   // Every valid cycle must present the scoreboard head; it is consumed only on accept
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (bus.iter_valid === 1'b1) begin
            total_valid++;
            chk("sb_underflow", 64'(sb.size() == 0), 64'd0);
            if (sb.size() != 0) begin
               chk("idx", 64'({bus.cur_i, bus.cur_j, bus.cur_k}), 64'({sb[0].i, sb[0].j, sb[0].k}));
               chk("addr_a", 64'(bus.addr_a), 64'(sb[0].a));
               chk("addr_b", 64'(bus.addr_b), 64'(sb[0].b));
               chk("addr_c", 64'(bus.addr_c), 64'(sb[0].c));
               chk("acc_flags", 64'({bus.acc_clear, bus.acc_last}), 64'({sb[0].clr, sb[0].last}));
               chk("iter_count_live", 64'(bus.iter_count), 64'(total_acc - run_base_acc));
               if (!bus.stall && !bus.abort) begin
                  void'(sb.pop_front());
                  total_acc++;
               end
            end
         end
      end
   endtask

   task automatic start_run(input int ni, input int nj, input int nk,
                            input logic [31:0] m1, input logic [31:0] m2, input logic [31:0] m3,
                            output int t);
      bus.num_i   = 16'(ni);
      bus.num_j   = 16'(nj);
      bus.num_k   = 16'(nk);
      bus.addr_m1 = m1;
      bus.addr_m2 = m2;
      bus.addr_m3 = m3;
      bus.start   = 1'b1;
      run_base_acc   = total_acc;
      run_base_valid = total_valid;
      push_run(ni, nj, nk, m1, m2, m3);
      tick();
      bus.start = 1'b0;
      t = cyc;
   endtask

   task automatic wait_done(input int limit, output int at);
      at = -1;
      for (int n = 0; n < limit; n++) begin
         if (bus.done === 1'b1) begin
            at = cyc;
            break;
         end
         tick();
      end
      chk("done_seen", 64'(at != -1), 64'd1);
   endtask

   initial begin
      int t;
      int at;
      bus.start   = 1'b0;
      bus.stall   = 1'b0;
      bus.abort   = 1'b0;
      bus.addr_m1 = '0;
      bus.addr_m2 = '0;
      bus.addr_m3 = '0;
      bus.num_i   = '0;
      bus.num_j   = '0;
      bus.num_k   = '0;
      fork
         monitor();
      join_none
      #2 reset = 1'b0;
      tick();
      tick();
      chk("reset_flags", 64'({bus.busy, bus.done, bus.err, bus.iter_valid, bus.acc_clear, bus.acc_last}), 64'd0);
      chk("reset_idx", 64'({bus.cur_i, bus.cur_j, bus.cur_k}), 64'd0);
      chk("reset_addr_ab", 64'({bus.addr_a, bus.addr_b}), 64'd0);
      chk("reset_addr_c_cnt", 64'({bus.addr_c, bus.iter_count}), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // 2x2x2, no stall
      start_run(2, 2, 2, 32'h100, 32'h200, 32'h300, t);
      chk("t1_check_busy", 64'(bus.busy), 64'd1);
      chk("t1_check_noiv", 64'(bus.iter_valid), 64'd0);
      wait_done(40, at);
      chk("t1_done_lat", 64'(at - t), 64'd9);
      chk("t1_valid_cycles", 64'(total_valid - run_base_valid), 64'd8);
      chk("t1_iter_count", 64'(bus.iter_count), 64'd8);
      chk("t1_err", 64'(bus.err), 64'd0);
      chk("t1_busy_done", 64'(bus.busy), 64'd0);
      chk("t1_sb_empty", 64'(sb.size()), 64'd0);
      tick();
      chk("t1_done_pulse", 64'(bus.done), 64'd0);

      // 1x3x4 with a 3-cycle stall on iteration 5
      start_run(1, 3, 4, 32'h1000, 32'h2000, 32'h3000, t);
      repeat (6) tick();
      bus.stall = 1'b1;
      repeat (3) tick();
      chk("t2_stall_cnt", 64'(bus.iter_count), 64'd5);
      bus.stall = 1'b0;
      wait_done(60, at);
      chk("t2_done_lat", 64'(at - t), 64'd16);
      chk("t2_valid_cycles", 64'(total_valid - run_base_valid), 64'd15);
      chk("t2_iter_count", 64'(bus.iter_count), 64'd12);
      chk("t2_err", 64'(bus.err), 64'd0);
      tick();
      chk("t2_done_pulse", 64'(bus.done), 64'd0);

      // zero dimension
      start_run(2, 0, 3, 32'h40, 32'h50, 32'h60, t);
      chk("t3_check_busy", 64'(bus.busy), 64'd1);
      tick();
      chk("t3_done", 64'(bus.done), 64'd1);
      chk("t3_err", 64'(bus.err), 64'd1);
      chk("t3_busy", 64'(bus.busy), 64'd0);
      chk("t3_iter_count", 64'(bus.iter_count), 64'd0);
      tick();
      chk("t3_done_pulse", 64'(bus.done), 64'd0);
      chk("t3_err_sticky", 64'(bus.err), 64'd1);
      chk("t3_valid_cycles", 64'(total_valid - run_base_valid), 64'd0);

      // 3x3x3 aborted at iteration 10, abort overriding a stall
      start_run(3, 3, 3, 32'h4000, 32'h5000, 32'h6000, t);
      repeat (11) tick();
      bus.abort = 1'b1;
      bus.stall = 1'b1;
      tick();
      bus.abort = 1'b0;
      bus.stall = 1'b0;
      chk("t4_done", 64'(bus.done), 64'd1);
      chk("t4_err", 64'(bus.err), 64'd1);
      chk("t4_iv", 64'(bus.iter_valid), 64'd0);
      chk("t4_iter_count", 64'(bus.iter_count), 64'd10);
      chk("t4_sb_left", 64'(sb.size()), 64'd17);
      sb.delete();
      tick();

      // follow-up run clears err; start pulses in RUN and DONE are ignored
      start_run(2, 1, 3, 32'h10, 32'h20, 32'h30, t);
      chk("t5_err_cleared", 64'(bus.err), 64'd0);
      repeat (3) tick();
      bus.num_i = 16'd7;
      bus.num_j = 16'd7;
      bus.num_k = 16'd7;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_done(40, at);
      chk("t5_done_lat", 64'(at - t), 64'd7);
      chk("t5_iter_count", 64'(bus.iter_count), 64'd6);
      chk("t5_err", 64'(bus.err), 64'd0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("t5_start_in_done", 64'({bus.busy, bus.done}), 64'd0);
      tick();
      chk("t5_idle_quiet", 64'({bus.busy, bus.iter_valid}), 64'd0);
      chk("t5_sb_empty", 64'(sb.size()), 64'd0);

      // asynchronous reset mid-run
      start_run(3, 3, 3, 32'h7000, 32'h8000, 32'h9000, t);
      repeat (5) tick();
      #2 reset = 1'b0;
      #1;
      chk("t6_rst_flags", 64'({bus.busy, bus.done, bus.err, bus.iter_valid}), 64'd0);
      chk("t6_rst_idx", 64'({bus.cur_i, bus.cur_j, bus.cur_k}), 64'd0);
      chk("t6_rst_addr", 64'({bus.addr_a, bus.addr_b}), 64'd0);
      chk("t6_rst_cnt", 64'({bus.addr_c, bus.iter_count}), 64'd0);
      sb.delete();
      tick();
      chk("t6_no_done_a", 64'(bus.done), 64'd0);
      #2 reset = 1'b1;
      tick();
      chk("t6_no_done_b", 64'({bus.done, bus.busy}), 64'd0);
      start_run(1, 1, 1, 32'hA00, 32'hB00, 32'hC00, t);
      wait_done(20, at);
      chk("t6_done_lat", 64'(at - t), 64'd2);
      chk("t6_iter_count", 64'(bus.iter_count), 64'd1);
      chk("t6_valid_cycles", 64'(total_valid - run_base_valid), 64'd1);
      chk("t6_sb_empty", 64'(sb.size()), 64'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
